// File: rtl/conv_arb_pkg.sv
// conv_arb_pkg: shared types and defaults for the convolution job arbiter.
package conv_arb_pkg;
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARB     = 3'd1,
        START   = 3'd2,
        RUN     = 3'd3,
        RELEASE = 3'd4
    } arb_state_t;

    localparam int NREQ_DEF    = 4;
    localparam int SIZE_W_DEF  = 5;
    localparam int GAP_DEF     = 2;
    localparam int TIMEOUT_DEF = 4096;
    localparam int TMO_W       = 13;
endpackage

// File: rtl/conv_job_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search starting just after the last winner.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        // Walk from farthest to nearest so the nearest set bit wins.
        for (int i = N; i >= 1; i--) begin
            if (req_i[(int'(last_i) + i) % N]) begin
                valid_o = 1'b1;
                idx_o   = IW'((int'(last_i) + i) % N);
            end
        end
        gnt_o = N'(valid_o) << idx_o;
    end
endmodule

// File: rtl/conv_job_arbiter.sv
// conv_job_arbiter: round-robin job sequencer for one shared convolution coprocessor.
// Optional watchdog enabled with `define CONV_ARB_TIMEOUT_EN.
module conv_job_arbiter
    import conv_arb_pkg::*;
#(
    parameter int NREQ    = NREQ_DEF,
    parameter int SIZE_W  = SIZE_W_DEF,
    parameter int GAP     = GAP_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_i,
    input  logic [NREQ*SIZE_W-1:0]   cfg_size_x_i,
    input  logic [NREQ*SIZE_W-1:0]   cfg_size_y_i,
    output logic [NREQ-1:0]          gnt_o,
    output logic [NREQ-1:0]          ack_o,
    output logic                     err_o,
    output logic                     copro_init_o,
    output logic [SIZE_W-1:0]        copro_size_x_o,
    output logic [SIZE_W-1:0]        copro_size_y_o,
    input  logic                     copro_busy_i,
    input  logic                     copro_done_i,
    output logic                     busy_o,
    output logic [$clog2(NREQ)-1:0]  owner_o
);
    localparam int IW = $clog2(NREQ);
    localparam int GW = $clog2(GAP + 1);

    if (NREQ < 2 || NREQ > 8 || GAP < 2 || TIMEOUT < 1 || TIMEOUT >= 2**TMO_W) begin : g_bad_cfg
        $error("conv_job_arbiter: parameter out of range");
    end

    arb_state_t        state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d, ack_q, ack_d, pick_gnt;
    logic [SIZE_W-1:0] sx_q, sx_d, sy_q, sy_d;
    logic [IW-1:0]     owner_q, owner_d, last_q, last_d, pick_idx;
    logic [GW-1:0]     gap_q, gap_d;
    logic              init_q, init_d, busy_q, busy_d, pick_valid;
    logic              done_hit, tmo_hit;
`ifdef CONV_ARB_TIMEOUT_EN
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              err_q, err_d;
`endif

    rr_pick #(.N(NREQ)) u_pick (
        .req_i   (req_i),
        .last_i  (last_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    assign done_hit = state_q == RUN && copro_done_i;
`ifdef CONV_ARB_TIMEOUT_EN
    assign tmo_hit = (state_q == START || state_q == RUN) && tmo_q == TMO_W'(TIMEOUT - 1);
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ack_d   = '0;
        sx_d    = sx_q;
        sy_d    = sy_q;
        owner_d = owner_q;
        last_d  = last_q;
        gap_d   = gap_q;
        init_d  = init_q;
`ifdef CONV_ARB_TIMEOUT_EN
        tmo_d   = (state_q == START || state_q == RUN) ? tmo_q + 1'b1 : tmo_q;
        err_d   = 1'b0;
`endif
        case (state_q)
            IDLE:    state_d = |req_i ? ARB : IDLE;
            ARB: begin
                state_d = pick_valid ? START : IDLE;
                if (pick_valid) begin
                    owner_d = pick_idx;
                    last_d  = pick_idx;
                    gnt_d   = pick_gnt;
                    sx_d    = cfg_size_x_i[pick_idx*SIZE_W +: SIZE_W];
                    sy_d    = cfg_size_y_i[pick_idx*SIZE_W +: SIZE_W];
                    init_d  = 1'b1;
`ifdef CONV_ARB_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end
            end
            START:   state_d = copro_busy_i ? RUN : START;
            RUN:     state_d = RUN;
            RELEASE: begin
                state_d = gap_q == '0 ? IDLE : RELEASE;
                gap_d   = gap_q == '0 ? gap_q : gap_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // gnt_q is already the one-hot of the owner, so it doubles as the ack pattern.
        if (done_hit || tmo_hit) begin
            state_d = RELEASE;
            ack_d   = gnt_q;
            gnt_d   = '0;
            init_d  = 1'b0;
            gap_d   = GW'(GAP - 1);
`ifdef CONV_ARB_TIMEOUT_EN
            err_d   = !done_hit;
`endif
        end
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ack_q   <= '0;
            sx_q    <= '0;
            sy_q    <= '0;
            owner_q <= '0;
            last_q  <= IW'(NREQ - 1);
            gap_q   <= '0;
            init_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef CONV_ARB_TIMEOUT_EN
            tmo_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            gap_q   <= gap_d;
            init_q  <= init_d;
            busy_q  <= busy_d;
`ifdef CONV_ARB_TIMEOUT_EN
            tmo_q   <= tmo_d;
            err_q   <= err_d;
`endif
        end
    end

    assign gnt_o          = gnt_q;
    assign ack_o          = ack_q;
    assign copro_init_o   = init_q;
    assign copro_size_x_o = sx_q;
    assign copro_size_y_o = sy_q;
    assign busy_o         = busy_q;
    assign owner_o        = owner_q;
`ifdef CONV_ARB_TIMEOUT_EN
    assign err_o          = err_q;
`else
    assign err_o          = 1'b0;
`endif
endmodule
